enemy_spawn_ctrl: RTL and testbench
===================================

Name: enemy_spawn_ctrl

Overview:
- Upstream controller for the two Enemy sprite instances. It decides when and in which lane each enemy is (re)spawned, and raises the enemy fall-speed accelerator as play progresses.
- Replaces the ad-hoc spawn logic in the top level with a clean FSM on a single clock.
- Consumes tick pulses from the CLK_Divider instances, enemy Y positions, and the ALU collision flag.
- Drives the Enemy enable/position inputs and the enemy CLK_Divider accelerator input.

Parameters:
- LANE_L, 197, x pixel of left lane
- LANE_C, 279, x pixel of centre lane
- LANE_R, 361, x pixel of right lane
- SPAWN_Y, 0, y loaded into a slot on spawn
- EXIT_Y, 480, slot is free once its enemy_y >= EXIT_Y
- MIN_GAP, 160, minimum y separation between two enemies in the same lane
- LEVEL_SPAWNS, 8, spawns per difficulty step
- ACCEL_STEP, 1000, accelerator increment per step
- ACCEL_MAX, 25'h186a0, accelerator saturation value
- SEED, 8'hA5, LFSR reset value (must be nonzero)

Ports:
- clk, in, 1, system clock (50 MHz)
- reset, in, 1, asynchronous, active-high
- start, in, 1, one-cycle pulse; begins or restarts play
- tick_spawn, in, 1, one-cycle spawn opportunity pulse
- collision, in, 1, level from ALU
- enemy_y0, in, 10, current y of slot 0
- enemy_y1, in, 10, current y of slot 1
- enable_o, out, 2, per-slot enemy enable (level)
- load_o, out, 2, per-slot one-cycle load pulse; x/y valid in the same cycle
- pos_x0, out, 10, lane x for slot 0
- pos_x1, out, 10, lane x for slot 1
- pos_y0, out, 10, spawn y for slot 0
- pos_y1, out, 10, spawn y for slot 1
- accel_o, out, 25, accelerator for enemy CLK_Divider
- score_o, out, 14, enemies passed; saturates at 16383
- state_o, out, 2, 0=IDLE, 1=RUN, 2=CRASH

Behaviour:
- Reset (async) values: state IDLE; enable_o=0; load_o=0; pos_x*=LANE_C; pos_y*=SPAWN_Y; accel_o=0; score_o=0; spawn counter=0; LFSR=SEED. All registers clear immediately, including mid-operation.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, shifts every clk in every state.
- Lane select uses lfsr[1:0]: 0 gives L, 1 gives C, 2 gives R, 3 gives C.
- IDLE: outputs held at reset values. start moves to RUN and clears score, accel and the spawn counter.
- RUN, slot exit:
  - Each cycle, an enabled slot whose enemy_y >= EXIT_Y clears its enable_o on the next edge.
  - score_o increments by 1 per exit, saturating.
- RUN, spawn on tick_spawn:
  - Uses slot-free status as registered at the start of the cycle. A slot freed in cycle N is spawnable from cycle N+1.
  - Target is the lowest-index free slot. If no slot is free, there is no spawn and nothing else changes.
  - Lane conflict: the other slot is enabled, in the same lane, and its enemy_y < SPAWN_Y+MIN_GAP. In that case the lane rotates L to C to R to L once. Two slots can never block all three lanes.
  - On spawn: the next edge sets enable_o[i]=1, pos_x/pos_y, and load_o[i]=1 for exactly one cycle. The spawn counter increments.
- Difficulty: when the spawn counter reaches LEVEL_SPAWNS, it resets to 0 and accel_o = min(accel_o+ACCEL_STEP, ACCEL_MAX). accel_o saturates and never wraps.
- CRASH:
  - Entered from RUN when collision=1. Collision beats tick_spawn in the same cycle, so no spawn occurs.
  - enable_o, pos, accel and score are frozen; load_o=0; exits are not counted.
  - start re-initialises as from IDLE and goes to RUN.
- start while in RUN is ignored. tick_spawn in IDLE or CRASH is ignored.
- Latency: input event to output is 1 clk. No combinational input-to-output paths.

Decomposition:
- Shared package (game_pkg):
  - Lane x constants
  - State encoding IDLE/RUN/CRASH
  - SPAWN_Y/EXIT_Y defaults
  - Accelerator width (25)
- Sub-module lfsr8 (clk, reset, seed, q[7:0]), reusable in place of the three Random_tiny instances.

Test Plan:
1. Reset then start, then tick_spawn with lfsr[1:0]=0 → next clk: enable_o=01, load_o=01 for 1 clk, pos_x0=197, pos_y0=0, state_o=1.
2. Slot 0 active at x=197 with enemy_y0=50; tick_spawn with lane L → slot 1 spawns at pos_x1=279 (rotated); repeat with enemy_y0=200 → pos_x1=197.
3. Both slots active; tick_spawn → no load_o. Drive enemy_y0=480 → enable_o[0] drops next clk and score_o=1. tick_spawn in that same cycle → no spawn; tick_spawn one cycle later → slot 0 spawns.
4. 8 spawns → accel_o=1000. Continue to 808 spawns → accel_o saturates at 100000 (25'h186a0) and stays there.
5. collision=1 and tick_spawn in the same cycle → state_o=2, no load_o, outputs frozen. start → state_o=1, score_o=0, accel_o=0.
6. Assert reset asynchronously mid-RUN between clk edges → all outputs at reset values before the next edge, LFSR=8'hA5.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants, state/lane encodings and lane helpers for the enemy spawn logic.
package game_pkg;

  localparam logic [9:0] LANE_L_X    = 10'd197;
  localparam logic [9:0] LANE_C_X    = 10'd279;
  localparam logic [9:0] LANE_R_X    = 10'd361;
  localparam logic [9:0] SPAWN_Y_DEF = 10'd0;
  localparam logic [9:0] EXIT_Y_DEF  = 10'd480;
  localparam int         ACCEL_W     = 25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CRASH = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    LN_L = 2'd0,
    LN_C = 2'd1,
    LN_R = 2'd2
  } lane_t;

  // Two random bits map onto three lanes; code 3 doubles up on the centre lane.
  function automatic lane_t lane_from_bits(input logic [1:0] bits);
    lane_t l;
    case (bits)
      2'd0:    l = LN_L;
      2'd2:    l = LN_R;
      default: l = LN_C;
    endcase
    return l;
  endfunction

  function automatic lane_t lane_rotate(input lane_t l);
    lane_t r;
    case (l)
      LN_L:    r = LN_C;
      LN_C:    r = LN_R;
      default: r = LN_L;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/enemy_spawn_ctrl_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), free-running, reloads its seed on reset.
module lfsr8 (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= seed;
    end else begin
      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
  end

endmodule

// File: rtl/enemy_spawn_ctrl.sv
// Spawn controller for the two enemy slots: lane choice, slot recycling,
// score counting and fall-speed difficulty ramp.
module enemy_spawn_ctrl
  import game_pkg::*;
#(
  parameter logic [9:0]         LANE_L       = LANE_L_X,
  parameter logic [9:0]         LANE_C       = LANE_C_X,
  parameter logic [9:0]         LANE_R       = LANE_R_X,
  parameter logic [9:0]         SPAWN_Y      = SPAWN_Y_DEF,
  parameter logic [9:0]         EXIT_Y       = EXIT_Y_DEF,
  parameter logic [9:0]         MIN_GAP      = 10'd160,
  parameter logic [7:0]         LEVEL_SPAWNS = 8'd8,
  parameter logic [ACCEL_W-1:0] ACCEL_STEP   = 25'd1000,
  parameter logic [ACCEL_W-1:0] ACCEL_MAX    = 25'h186a0,
  parameter logic [7:0]         SEED         = 8'hA5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               tick_spawn,
  input  logic               collision,
  input  logic [9:0]         enemy_y0,
  input  logic [9:0]         enemy_y1,
  output logic [1:0]         enable_o,
  output logic [1:0]         load_o,
  output logic [9:0]         pos_x0,
  output logic [9:0]         pos_x1,
  output logic [9:0]         pos_y0,
  output logic [9:0]         pos_y1,
  output logic [ACCEL_W-1:0] accel_o,
  output logic [13:0]        score_o,
  output logic [1:0]         state_o
);

  state_t             state;
  logic [7:0]         lfsr;
  logic [7:0]         spawn_cnt;
  logic [1:0]         exit_hit;
  logic [1:0]         spawn_mask;
  logic               spawn_ok;
  logic               target;
  logic               other_en;
  logic               conflict;
  logic [9:0]         other_x;
  logic [9:0]         other_y;
  lane_t              base_lane;
  lane_t              lane;
  logic [9:0]         lane_x;
  logic [14:0]        score_sum;
  logic [13:0]        score_next;
  logic [ACCEL_W:0]   accel_sum;
  logic [ACCEL_W-1:0] accel_next;
  logic               unused_lfsr;

  function automatic logic [9:0] lane_x_of(input lane_t l);
    logic [9:0] x;
    case (l)
      LN_L:    x = LANE_L;
      LN_R:    x = LANE_R;
      default: x = LANE_C;
    endcase
    return x;
  endfunction

  lfsr8 u_lfsr (
    .clk  (clk),
    .reset(reset),
    .seed (SEED),
    .q    (lfsr)
  );

  assign unused_lfsr = ^lfsr[7:2];
  assign state_o     = state;

  // Slot choice uses the enables registered at cycle start, so a slot leaving now is not reusable yet.
  always_comb begin
    exit_hit[0] = enable_o[0] && (enemy_y0 >= EXIT_Y);
    exit_hit[1] = enable_o[1] && (enemy_y1 >= EXIT_Y);
    target      = enable_o[0];
    spawn_ok    = tick_spawn && !(&enable_o);
    spawn_mask  = spawn_ok ? (target ? 2'b10 : 2'b01) : 2'b00;
    other_en    = target ? enable_o[0] : enable_o[1];
    other_x     = target ? pos_x0 : pos_x1;
    other_y     = target ? enemy_y0 : enemy_y1;
    base_lane   = lane_from_bits(lfsr[1:0]);
    conflict    = other_en && (other_x == lane_x_of(base_lane)) &&
                  ({1'b0, other_y} < ({1'b0, SPAWN_Y} + {1'b0, MIN_GAP}));
    lane        = conflict ? lane_rotate(base_lane) : base_lane;
    lane_x      = lane_x_of(lane);
    score_sum   = {1'b0, score_o} + {14'd0, exit_hit[0]} + {14'd0, exit_hit[1]};
    score_next  = score_sum[14] ? 14'h3fff : score_sum[13:0];
    accel_sum   = {1'b0, accel_o} + {1'b0, ACCEL_STEP};
    accel_next  = (accel_sum > {1'b0, ACCEL_MAX}) ? ACCEL_MAX : accel_sum[ACCEL_W-1:0];
  end

  // Play FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      enable_o  <= 2'b00;
      load_o    <= 2'b00;
      pos_x0    <= LANE_C;
      pos_x1    <= LANE_C;
      pos_y0    <= SPAWN_Y;
      pos_y1    <= SPAWN_Y;
      accel_o   <= '0;
      score_o   <= 14'd0;
      spawn_cnt <= 8'd0;
    end else begin
      load_o <= 2'b00;
      case (state)
        ST_IDLE, ST_CRASH: begin
          if (start) begin
            state     <= ST_RUN;
            enable_o  <= 2'b00;
            pos_x0    <= LANE_C;
            pos_x1    <= LANE_C;
            pos_y0    <= SPAWN_Y;
            pos_y1    <= SPAWN_Y;
            accel_o   <= '0;
            score_o   <= 14'd0;
            spawn_cnt <= 8'd0;
          end
        end
        ST_RUN: begin
          if (collision) begin
            state <= ST_CRASH;
          end else begin
            enable_o <= (enable_o & ~exit_hit) | spawn_mask;
            score_o  <= score_next;
            if (spawn_ok) begin
              load_o <= spawn_mask;
              if (target) begin
                pos_x1 <= lane_x;
                pos_y1 <= SPAWN_Y;
              end else begin
                pos_x0 <= lane_x;
                pos_y0 <= SPAWN_Y;
              end
              if (spawn_cnt == LEVEL_SPAWNS - 8'd1) begin
                spawn_cnt <= 8'd0;
                accel_o   <= accel_next;
              end else begin
                spawn_cnt <= spawn_cnt + 8'd1;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_spawn_ctrl.sv
// Randomized bench for enemy_spawn_ctrl against a behavioural game-rule model.
module tb_enemy_spawn_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, tick_spawn, collision;
  logic [9:0]  enemy_y0, enemy_y1;
  logic [1:0]  enable_o, load_o, state_o;
  logic [9:0]  pos_x0, pos_x1, pos_y0, pos_y1;
  logic [24:0] accel_o;
  logic [13:0] score_o;

  always #5 clk = ~clk;

  enemy_spawn_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .tick_spawn(tick_spawn),
    .collision(collision), .enemy_y0(enemy_y0), .enemy_y1(enemy_y1),
    .enable_o(enable_o), .load_o(load_o), .pos_x0(pos_x0), .pos_x1(pos_x1),
    .pos_y0(pos_y0), .pos_y1(pos_y1), .accel_o(accel_o), .score_o(score_o),
    .state_o(state_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model: game-level quantities only
  int         m_state;
  logic [1:0] m_en, m_load;
  int         m_x[2];
  int         m_score, m_spawns;
  logic [7:0] m_lfsr;
  int         lanes[4] = '{197, 279, 361, 279};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rot(input int x);
    if (x == 197) return 279;
    if (x == 279) return 361;
    return 197;
  endfunction

  function automatic int exp_accel(input int s);
    int a;
    a = (s / 8) * 1000;
    return (a > 100000) ? 100000 : a;
  endfunction

  task automatic model_reset();
    m_state = 0; m_en = 2'b00; m_load = 2'b00;
    m_x[0] = 279; m_x[1] = 279;
    m_score = 0; m_spawns = 0; m_lfsr = 8'hA5;
  endtask

  task automatic model_step();
    int ys[2];
    logic [1:0] n_en;
    int exits, tgt, lx;
    ys[0] = enemy_y0; ys[1] = enemy_y1;
    exits = 0; tgt = -1;
    m_load = 2'b00;
    if (m_state != 1) begin
      if (start) begin
        m_state = 1; m_en = 2'b00; m_x[0] = 279; m_x[1] = 279;
        m_score = 0; m_spawns = 0;
      end
    end else if (collision) begin
      m_state = 2;
    end else begin
      n_en = m_en;
      for (int i = 0; i < 2; i++)
        if (m_en[i] && ys[i] >= 480) begin n_en[i] = 1'b0; exits++; end
      if (tick_spawn) begin
        if (!m_en[0]) tgt = 0; else if (!m_en[1]) tgt = 1;
        if (tgt >= 0) begin
          lx = lanes[m_lfsr[1:0]];
          if (m_en[1-tgt] && m_x[1-tgt] == lx && ys[1-tgt] < 160) lx = rot(lx);
          n_en[tgt] = 1'b1; m_x[tgt] = lx; m_load[tgt] = 1'b1; m_spawns++;
        end
      end
      m_en = n_en;
      m_score = (m_score + exits > 16383) ? 16383 : m_score + exits;
    end
    m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'b1011_1000)};
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".enable"}, enable_o, m_en);
    check({tag, ".load"},   load_o,   m_load);
    check({tag, ".pos_x0"}, pos_x0,   m_x[0]);
    check({tag, ".pos_x1"}, pos_x1,   m_x[1]);
    check({tag, ".pos_y0"}, pos_y0,   0);
    check({tag, ".pos_y1"}, pos_y1,   0);
    check({tag, ".accel"},  accel_o,  exp_accel(m_spawns));
    check({tag, ".score"},  score_o,  m_score);
    check({tag, ".state"},  state_o,  m_state);
  endtask

  // inputs are changed at negedge; model advances, edge happens, outputs compared 1ns later
  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic wait_lane_l();
    int guard;
    guard = 0;
    tick_spawn = 1'b0;
    while (m_lfsr[1:0] != 2'd0 && guard < 300) begin
      step("wait");
      guard++;
    end
    check("lane_wait_budget", guard < 300, 1);
  endtask

  initial begin
    int guard, s0;
    reset = 1'b1; start = 1'b0; tick_spawn = 1'b0; collision = 1'b0;
    enemy_y0 = 10'd0; enemy_y1 = 10'd0;
    #2;
    model_reset();
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // 1: first spawn in lane L
    start = 1'b1; step("start"); start = 1'b0;
    check("t1_state", state_o, 1);
    wait_lane_l();
    tick_spawn = 1'b1; step("t1"); tick_spawn = 1'b0;
    check("t1_enable", enable_o, 2'b01);
    check("t1_load", load_o, 2'b01);
    check("t1_x0", pos_x0, 197);
    step("t1b");
    check("t1_load_once", load_o, 2'b00);

    // 2: lane conflict rotation, then no rotation when far enough apart
    enemy_y0 = 10'd50;
    wait_lane_l();
    tick_spawn = 1'b1; step("t2a"); tick_spawn = 1'b0;
    check("t2_rotated_x1", pos_x1, 279);
    enemy_y1 = 10'd480; step("t2_exit1"); enemy_y1 = 10'd0;
    check("t2_slot1_freed", enable_o, 2'b01);
    enemy_y0 = 10'd200;
    wait_lane_l();
    tick_spawn = 1'b1; step("t2b"); tick_spawn = 1'b0;
    check("t2_unrotated_x1", pos_x1, 197);

    // 3: full slots, exit, spawn one cycle after the exit
    tick_spawn = 1'b1; step("t3_full");
    check("t3_no_load", load_o, 2'b00);
    s0 = m_score;
    enemy_y0 = 10'd480; step("t3_exit");
    check("t3_en_drop", enable_o, 2'b10);
    check("t3_no_load_same", load_o, 2'b00);
    check("t3_score_inc", score_o, s0 + 1);
    enemy_y0 = 10'd0; step("t3_respawn"); tick_spawn = 1'b0;
    check("t3_load_slot0", load_o, 2'b01);

    // 4: randomized run through accelerator saturation
    guard = 0;
    while (m_spawns < 810 && guard < 30000) begin
      tick_spawn = 1'($urandom_range(0, 1));
      enemy_y0 = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 479)) : 10'd480;
      enemy_y1 = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 479)) : 10'd480;
      step("t4");
      guard++;
    end
    check("t4_budget", m_spawns >= 810, 1);
    check("t4_accel_sat", accel_o, 25'h186a0);

    // 5: collision beats tick_spawn, then frozen, then restart
    tick_spawn = 1'b0;
    enemy_y0 = 10'd480; enemy_y1 = 10'd480; step("t5_free");
    enemy_y0 = 10'd0; enemy_y1 = 10'd0;
    collision = 1'b1; tick_spawn = 1'b1; step("t5_crash");
    check("t5_state", state_o, 2);
    check("t5_no_load", load_o, 2'b00);
    for (int i = 0; i < 12; i++) begin
      collision  = 1'($urandom_range(0, 1));
      tick_spawn = 1'($urandom_range(0, 1));
      enemy_y0   = 10'($urandom_range(0, 600));
      enemy_y1   = 10'($urandom_range(0, 600));
      step("t5_frozen");
    end
    collision = 1'b0; tick_spawn = 1'b0;
    start = 1'b1; step("t5_restart"); start = 1'b0;
    check("t5_restart_state", state_o, 1);
    check("t5_restart_score", score_o, 0);
    check("t5_restart_accel", accel_o, 0);

    // mixed random play with occasional collisions and restarts
    for (int i = 0; i < 600; i++) begin
      start      = ($urandom_range(0, 15) == 0);
      collision  = ($urandom_range(0, 31) == 0);
      tick_spawn = 1'($urandom_range(0, 1));
      enemy_y0   = 10'($urandom_range(0, 600));
      enemy_y1   = 10'($urandom_range(0, 600));
      step("mix");
    end

    // 6: asynchronous reset between edges mid-run
    start = 1'b0; collision = 1'b0;
    if (m_state != 1) begin start = 1'b1; step("t6_start"); start = 1'b0; end
    tick_spawn = 1'b1; enemy_y0 = 10'd0; enemy_y1 = 10'd0;
    step("t6_a"); step("t6_b");
    tick_spawn = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("t6_async");
    check("t6_lfsr", dut.u_lfsr.q, 8'hA5);
    #2;
    reset = 1'b0;
    step("t6_after");
    start = 1'b1; step("t6_restart"); start = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
